bcd_sale_accumulator: RTL and testbench
=======================================

Name: bcd_sale_accumulator

Overview:
Downstream consumer of the BCD multiplier. Takes each line-item product (price × quantity, 4 BCD digits) and adds it into a running 6-digit BCD sale total. The add is digit-serial: one BCD digit per clock, driven by an FSM, with a valid/ready handshake. Exposes the total, item count, a sticky overflow flag and per-item completion/error strobes to the display and control logic.

Parameters:
IN_DIGITS, 4, BCD digits on ADD_VALUE; must be ≤ TOTAL_DIGITS
TOTAL_DIGITS, 6, BCD digits in TOTAL
CNT_W, 8, width of binary ITEM_COUNT

Ports:
CLK  in  1  rising-edge clock
RST  in  1  synchronous reset, active-high
ADD_VALID  in  1  ADD_VALUE holds an item product
ADD_VALUE  in  4*IN_DIGITS  BCD product; digit 0 in [3:0]
ADD_READY  out  1  accumulator can accept an item
CLEAR  in  1  start a new sale; zeroes the accumulator state
TOTAL  out  4*TOTAL_DIGITS  running BCD total
ITEM_COUNT  out  CNT_W  accepted valid items, binary
OVERFLOW  out  1  sticky; total saturated
DONE  out  1  one-cycle strobe: item finished
BCD_ERR  out  1  qualifies DONE: item rejected as non-BCD

Behaviour:
- Reset (RST high at an edge) forces the following. State IDLE, TOTAL=0, ITEM_COUNT=0, OVERFLOW=0, DONE=0, BCD_ERR=0, internal digit index=0. RST has priority over everything else.
- ADD_READY = (state==IDLE) && !CLEAR. An item is accepted at an edge where ADD_VALID && ADD_READY.
- States: IDLE, ADD, FIN.
  - IDLE→ADD on accept. At accept, ADD_VALUE is latched, zero-extended to TOTAL_DIGITS, the carry is cleared and the digit index is set to 0.
  - IDLE→FIN on accept if any input nibble is >9. In this case BCD_ERR=1 in FIN, and TOTAL and ITEM_COUNT are unchanged.
  - ADD: each cycle computes s = TOTAL[idx] + operand[idx] + carry, on 5 bits.
    - If s > 9: digit = s+6 (low nibble) and carry = 1. Otherwise digit = s and carry = 0.
    - The result digit is written into a shadow register and idx is incremented.
    - After idx == TOTAL_DIGITS-1 the FSM goes to FIN.
  - FIN: DONE=1 for exactly this cycle, then unconditionally returns to IDLE.
- Commit happens at the ADD→FIN edge:
  - If the final carry is 0: TOTAL ← shadow.
  - If the final carry is 1: TOTAL ← all digits 9, and OVERFLOW is set. OVERFLOW stays set until CLEAR or RST.
  - ITEM_COUNT increments on the same edge and saturates at 2^CNT_W-1.
- TOTAL never shows partial sums. It changes only at commit, CLEAR or RST.
- Latency: accept edge E0; ADD cycles occupy E1..E6 (TOTAL_DIGITS cycles); TOTAL updates at E6; DONE is high in the cycle after E6; ADD_READY is high again after E7. The item period is TOTAL_DIGITS+2 cycles.
- Non-BCD path: accept at E0, FIN in the following cycle, then IDLE.
- CLEAR (not RST) at any edge:
  - TOTAL=0, ITEM_COUNT=0, OVERFLOW=0, state=IDLE.
  - Any in-flight add is aborted and discarded; no DONE is produced for it.
  - CLEAR together with ADD_VALID in IDLE: CLEAR wins and the item is not accepted.
- DONE and BCD_ERR are 0 in every state except FIN.
- An add while OVERFLOW is already set still runs. The result remains all 9s; adding 0 leaves the total unchanged.
- ADD_VALUE and ADD_VALID are ignored while not in IDLE. The upstream block must hold ADD_VALID until it sees ADD_READY.

Test Plan:
1. Apply RST for 2 cycles with ADD_VALID=1 → TOTAL=000000, ITEM_COUNT=0, OVERFLOW=0, DONE=0, ADD_READY=1 after reset is released.
2. Add 0x0123, then add 0x0456 → TOTAL=0x000123, then 0x000579. Each DONE comes exactly 7 cycles after its accept edge, and ITEM_COUNT=2.
3. Carry chain: preload by adding 0x9999, then add 0x0001 → TOTAL=0x010000. No change to TOTAL is visible before the commit edge.
4. Overflow: bring TOTAL to 0x999990 (100 adds of 0x9999, then top up), then add 0x0010 → TOTAL=0x999999 and OVERFLOW=1. A further add of 0x0005 keeps 0x999999 with OVERFLOW still 1.
5. Non-BCD: with TOTAL=0x000579, add 0x0A12 → DONE=1 with BCD_ERR=1 one cycle after accept. TOTAL stays 0x000579 and ITEM_COUNT is unchanged.
6. Abort: assert CLEAR in the 3rd ADD cycle of 0x0456 → TOTAL=0, ITEM_COUNT=0, no DONE, ADD_READY=1 the next cycle. Then CLEAR together with ADD_VALID in IDLE → item not accepted.

Source files
------------

// File: rtl/bcd_sale_accumulator.sv
// Running BCD sale total: each accepted item is added one digit per clock,
// then committed at once (or saturated to all nines on final carry-out).
module bcd_sale_accumulator #(
  parameter int IN_DIGITS    = 4,
  parameter int TOTAL_DIGITS = 6,
  parameter int CNT_W        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      add_valid_i,
  input  logic [4*IN_DIGITS-1:0]    add_value_i,
  output logic                      add_ready_o,
  input  logic                      clear_i,
  output logic [4*TOTAL_DIGITS-1:0] total_o,
  output logic [CNT_W-1:0]          item_count_o,
  output logic                      overflow_o,
  output logic                      done_o,
  output logic                      bcd_err_o
);

  localparam int IDX_W = (TOTAL_DIGITS > 1) ? $clog2(TOTAL_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

  state_t                    state_q, state_d;
  logic [4*TOTAL_DIGITS-1:0] total_q, total_d;
  logic [4*TOTAL_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*TOTAL_DIGITS-1:0] operand_q, operand_d;
  logic                      carry_q, carry_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic                      err_q, err_d;

  logic                      in_bcd_ok;
  logic [4:0]                sum;
  logic [4:0]                sum_adj;
  logic [3:0]                sum_digit;
  logic                      sum_carry;

  always_comb begin
    in_bcd_ok = 1'b1;
    for (int i = 0; i < IN_DIGITS; i++) begin
      if (add_value_i[4*i +: 4] > 4'd9) in_bcd_ok = 1'b0;
    end
  end

  // One decimal digit of the sum; +6 skips the six unused nibble codes.
  always_comb begin
    sum       = {1'b0, total_q[4*idx_q +: 4]} + {1'b0, operand_q[4*idx_q +: 4]}
              + {4'b0000, carry_q};
    sum_adj   = sum + 5'd6;
    sum_carry = (sum > 5'd9);
    sum_digit = sum_carry ? sum_adj[3:0] : sum[3:0];
  end

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    shadow_d  = shadow_q;
    operand_d = operand_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    err_d     = err_q;

    if (clear_i) begin
      state_d = IDLE;
      total_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (add_valid_i) begin
            operand_d                  = '0;
            operand_d[4*IN_DIGITS-1:0] = add_value_i;
            carry_d                    = 1'b0;
            idx_d                      = '0;
            err_d                      = !in_bcd_ok;
            state_d                    = in_bcd_ok ? ADD : FIN;
          end
        end
        ADD: begin
          shadow_d[4*idx_q +: 4] = sum_digit;
          carry_d                = sum_carry;
          if (idx_q == IDX_W'(TOTAL_DIGITS - 1)) begin
            state_d = FIN;
            total_d = sum_carry ? {TOTAL_DIGITS{4'h9}} : shadow_d;
            if (sum_carry) ovf_d = 1'b1;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        FIN: begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      total_q   <= '0;
      shadow_q  <= '0;
      operand_q <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      shadow_q  <= shadow_d;
      operand_q <= operand_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign add_ready_o  = (state_q == IDLE) && !clear_i;
  assign total_o      = total_q;
  assign item_count_o = count_q;
  assign overflow_o   = ovf_q;
  assign done_o       = (state_q == FIN);
  assign bcd_err_o    = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_bcd_sale_accumulator.sv
// Checks bcd_sale_accumulator against an integer-arithmetic sale model every
// cycle, plus directed scenarios with hand-computed expected values.
module tb_bcd_sale_accumulator;

  localparam int TD     = 6;
  localparam int MAXTOT = 999999;
  localparam int MAXCNT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        addValid;
  logic [15:0] addValue;
  logic        addReady;
  logic        clear;
  logic [23:0] total;
  logic [7:0]  itemCount;
  logic        overflow;
  logic        done;
  logic        bcdErr;

  int nChecks = 0;
  int nFails  = 0;
  bit checking = 0;

  int mTotal, mCount, mVal, mBusy;
  bit mOvf, mErr;

  always #5 clk = ~clk;

  bcd_sale_accumulator #(.IN_DIGITS(4), .TOTAL_DIGITS(6), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .add_valid_i(addValid), .add_value_i(addValue),
    .add_ready_o(addReady), .clear_i(clear), .total_o(total),
    .item_count_o(itemCount), .overflow_o(overflow), .done_o(done),
    .bcd_err_o(bcdErr)
  );

  function automatic int bcd2int(input logic [23:0] v);
    int r = 0;
    for (int i = 5; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [23:0] int2bcd(input int n);
    logic [23:0] r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic bit isBcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic logic [15:0] randValue(input bit allowBad);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allowBad && $urandom_range(0, 7) == 0)
      v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Item lifecycle counted in cycles since accept: 1..TD adding, TD+1 = finish.
  always @(posedge clk) begin
    if (rst) begin
      mTotal = 0; mCount = 0; mOvf = 0; mBusy = 0; mErr = 0;
    end else if (clear) begin
      mTotal = 0; mCount = 0; mOvf = 0; mBusy = 0; mErr = 0;
    end else if (mBusy == 0) begin
      if (addValid) begin
        mVal = bcd2int({8'h00, addValue});
        mErr = !isBcd(addValue);
        mBusy = mErr ? TD + 1 : 1;
      end
    end else if (mBusy == TD + 1) begin
      mBusy = 0;
      mErr  = 0;
    end else begin
      mBusy++;
      if (mBusy == TD + 1) begin
        if (mTotal + mVal > MAXTOT) begin
          mTotal = MAXTOT;
          mOvf   = 1;
        end else begin
          mTotal = mTotal + mVal;
        end
        if (mCount < MAXCNT) mCount++;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_total", total, int2bcd(mTotal));
      checkOutput("cyc_count", itemCount, mCount);
      checkOutput("cyc_overflow", overflow, mOvf);
      checkOutput("cyc_done", done, mBusy == TD + 1);
      checkOutput("cyc_bcd_err", bcdErr, (mBusy == TD + 1) && mErr);
      checkOutput("cyc_ready", addReady, (mBusy == 0) && !clear);
    end
  end

  // Offers one item, waits for acceptance and DONE; lat = edges from accept to DONE.
  task automatic applyStimulus(input logic [15:0] v, output int lat, output bit errSeen);
    bit accepted = 0;
    lat = -1;
    errSeen = 0;
    addValid = 1'b1;
    addValue = v;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (addReady) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 0, 1);
      addValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 addValid = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (done) begin
        lat = e;
        errSeen = bcdErr;
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyClear();
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat, nBcd;
    bit  err, sawDone;
    logic [15:0] v;

    rst = 1'b1; addValid = 1'b1; addValue = 16'h1234; clear = 1'b0;
    @(posedge clk);
    #1 checking = 1;
    @(posedge clk);
    #1 rst = 1'b0; addValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_total", total, 24'h000000);
    checkOutput("rst_count", itemCount, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ready", addReady, 1);
    @(posedge clk);
    #1;

    applyStimulus(16'h0123, lat, err);
    checkOutput("add1_total", total, 24'h000123);
    checkOutput("add1_latency", lat, 6);
    applyStimulus(16'h0456, lat, err);
    checkOutput("add2_total", total, 24'h000579);
    checkOutput("add2_latency", lat, 6);
    checkOutput("add2_count", itemCount, 2);

    applyStimulus(16'h0A12, lat, err);
    checkOutput("nonbcd_latency", lat, 0);
    checkOutput("nonbcd_err", err, 1);
    checkOutput("nonbcd_total", total, 24'h000579);
    checkOutput("nonbcd_count", itemCount, 2);

    applyClear();
    applyStimulus(16'h9999, lat, err);
    applyStimulus(16'h0001, lat, err);
    checkOutput("carry_total", total, 24'h010000);
    checkOutput("carry_err", err, 0);

    applyClear();
    for (int i = 0; i < 100; i++) applyStimulus(16'h9999, lat, err);
    checkOutput("ovf_pre_total", total, 24'h999900);
    applyStimulus(16'h0090, lat, err);
    checkOutput("ovf_topup_total", total, 24'h999990);
    checkOutput("ovf_topup_flag", overflow, 0);
    applyStimulus(16'h0010, lat, err);
    checkOutput("ovf_total", total, 24'h999999);
    checkOutput("ovf_flag", overflow, 1);
    applyStimulus(16'h0005, lat, err);
    checkOutput("ovf_again_total", total, 24'h999999);
    checkOutput("ovf_again_flag", overflow, 1);
    applyStimulus(16'h0000, lat, err);
    checkOutput("ovf_zero_total", total, 24'h999999);

    applyClear();
    applyStimulus(16'h0123, lat, err);
    addValid = 1'b1; addValue = 16'h0456;
    @(posedge clk);
    #1 addValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    checkOutput("abort_total", total, 24'h000000);
    checkOutput("abort_count", itemCount, 0);
    checkOutput("abort_ready", addReady, 1);
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("abort_no_done", sawDone, 0);

    @(posedge clk);
    #1 addValid = 1'b1; addValue = 16'h0111; clear = 1'b1;
    @(posedge clk);
    #1 addValid = 1'b0; clear = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("clrvalid_no_done", sawDone, 0);
    checkOutput("clrvalid_count", itemCount, 0);
    checkOutput("clrvalid_ready", addReady, 1);
    @(posedge clk);
    #1;

    applyClear();
    nBcd = 0;
    for (int i = 0; i < 300; i++) begin
      v = randValue(1);
      if (isBcd(v)) nBcd++;
      applyStimulus(v, lat, err);
      checkOutput("rnd_latency", lat, isBcd(v) ? 6 : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    checkOutput("rnd_count_sat", itemCount, (nBcd > MAXCNT) ? MAXCNT : nBcd);

    applyClear();
    for (int i = 0; i < 400; i++) begin
      addValid = 1'($urandom_range(0, 1));
      addValue = randValue(1);
      clear    = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    addValid = 1'b0; clear = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
